// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode map, control bundle and field constants.
// Instruction format: [31:25] opcode, [24:20] rd, [19:15] rs1, [14:10] rs2, [9:0] imm.
package decode_pkg;

  typedef enum logic [6:0] {
    OpNop    = 7'd0,
    OpAdd    = 7'd1,
    OpAddi   = 7'd2,
    OpSub    = 7'd3,
    OpLd     = 7'd4,
    OpSt     = 7'd5,
    OpBeq    = 7'd6,
    OpJal    = 7'd7,
    OpVadd   = 7'd8,
    OpVmul   = 7'd9,
    OpVldi   = 7'd10,
    OpVsti   = 7'd11,
    OpVldr   = 7'd12,
    OpVstr   = 7'd13,
    OpMatmul = 7'd14,
    OpHalt   = 7'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ValuNone = 2'd0,
    ValuAdd  = 2'd1,
    ValuMul  = 2'd2
  } valu_op_e;

  localparam logic [2:0] ImmNone = 3'd0;
  localparam logic [2:0] ImmI    = 3'd1;
  localparam logic [2:0] ImmJ    = 3'd2;

  localparam logic [1:0] BjNone   = 2'd0;
  localparam logic [1:0] BjBranch = 2'd1;
  localparam logic [1:0] BjJump   = 2'd2;

  localparam logic [1:0] MmMul    = 2'd0;
  localparam logic [1:0] MmMulAcc = 2'd1;
  localparam logic [1:0] MmClear  = 2'd2;

  typedef struct packed {
    opcode_e     opcode;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic [1:0]  branch_jump;
    logic [1:0]  matmul_op;
    valu_op_e    valu_op;
    logic        alu_sub;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        r_read1;
    logic        r_read2;
    logic        v_read1;
    logic        v_read2;
    logic        r_write;
    logic        v_write;
    logic        mem_read;
    logic        mem_write;
    logic        vmem;
    logic        halt;
  } ctrl_t;

  function automatic logic [31:0] sext(input logic [19:0] v, input int unsigned msb);
    logic [31:0] r;
    r = {12'd0, v};
    for (int i = 0; i < 32; i++) begin
      if (i > msb) r[i] = v[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_sequencer_inst_decoder.sv
// Combinational instruction decoder.
//   i_inst : 32-bit instruction
//   o_ctrl : control bundle incl. register fields and read/write enables
// Undefined opcodes (and nop) yield an all-zero bundle.
module inst_decoder
  import decode_pkg::*;
(
  input  logic [31:0] i_inst,
  output ctrl_t       o_ctrl
);

  logic w_known;

  always_comb begin
    o_ctrl  = '0;
    w_known = 1'b1;
    case (i_inst[31:25])
      OpAdd, OpSub: begin
        o_ctrl.r_read1 = 1'b1;
        o_ctrl.r_read2 = 1'b1;
        o_ctrl.r_write = 1'b1;
        o_ctrl.alu_sub = (i_inst[31:25] == OpSub);
      end
      OpAddi, OpLd: begin
        o_ctrl.r_read1  = 1'b1;
        o_ctrl.r_write  = 1'b1;
        o_ctrl.imm_type = ImmI;
        o_ctrl.mem_read = (i_inst[31:25] == OpLd);
      end
      OpSt: begin
        o_ctrl.r_read1   = 1'b1;
        o_ctrl.r_read2   = 1'b1;
        o_ctrl.imm_type  = ImmI;
        o_ctrl.mem_write = 1'b1;
      end
      OpBeq: begin
        o_ctrl.r_read1     = 1'b1;
        o_ctrl.r_read2     = 1'b1;
        o_ctrl.imm_type    = ImmI;
        o_ctrl.branch_jump = BjBranch;
      end
      OpJal: begin
        o_ctrl.r_write     = 1'b1;
        o_ctrl.imm_type    = ImmJ;
        o_ctrl.branch_jump = BjJump;
      end
      OpVadd, OpVmul: begin
        o_ctrl.v_read1 = 1'b1;
        o_ctrl.v_read2 = 1'b1;
        o_ctrl.v_write = 1'b1;
        o_ctrl.valu_op = (i_inst[31:25] == OpVadd) ? ValuAdd : ValuMul;
      end
      // Vector loads: scalar base in rs1; vldr adds a scalar offset register in rs2.
      OpVldi, OpVldr: begin
        o_ctrl.r_read1  = 1'b1;
        o_ctrl.r_read2  = (i_inst[31:25] == OpVldr);
        o_ctrl.v_write  = 1'b1;
        o_ctrl.mem_read = 1'b1;
        o_ctrl.vmem     = 1'b1;
        o_ctrl.imm_type = (i_inst[31:25] == OpVldi) ? ImmI : ImmNone;
      end
      // Vector stores: scalar base in rs1, vector data in rs2.
      OpVsti, OpVstr: begin
        o_ctrl.r_read1   = 1'b1;
        o_ctrl.v_read2   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.vmem      = 1'b1;
        o_ctrl.imm_type  = (i_inst[31:25] == OpVsti) ? ImmI : ImmNone;
      end
      OpMatmul: begin
        o_ctrl.v_read1   = 1'b1;
        o_ctrl.v_read2   = 1'b1;
        o_ctrl.v_write   = 1'b1;
        o_ctrl.matmul_op = (i_inst[1:0] == 2'd3) ? MmMul : i_inst[1:0];
      end
      OpHalt: o_ctrl.halt = 1'b1;
      default: w_known = 1'b0;
    endcase

    if (w_known) begin
      o_ctrl.opcode = opcode_e'(i_inst[31:25]);
      o_ctrl.rd     = i_inst[24:20];
      o_ctrl.rs1    = i_inst[19:15];
      o_ctrl.rs2    = i_inst[14:10];
      unique case (o_ctrl.imm_type)
        ImmI:    o_ctrl.imm = sext({10'd0, i_inst[9:0]}, 9);
        ImmJ:    o_ctrl.imm = sext(i_inst[19:0], 19);
        default: o_ctrl.imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Registered decode stage with vector-memory beat expansion and register scoreboard.
//   in_*      : fetch-side valid/ready handshake (instruction, PC)
//   out_*     : one-entry registered micro-op (control bundle, PC, beat index, last flag)
//   wb_s/wb_v : scalar/vector writeback completions clearing the scoreboard
//   flush     : redirect, drops held micro-op and any beat sequence
//   halted    : a halt micro-op has been consumed; stage stays closed until rst
module decode_sequencer
  import decode_pkg::*;
#(
  parameter int unsigned VBEATS    = 4,
  parameter int unsigned NUM_SREGS = 32,
  parameter int unsigned NUM_VREGS = 32,
  parameter int unsigned PC_W      = 32,
  localparam int unsigned BeatW    = (VBEATS > 1) ? $clog2(VBEATS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_t            out_ctrl,
  output logic [PC_W-1:0]  out_pc,
  output logic [BeatW-1:0] out_beat,
  output logic             out_last,
  input  logic             wb_s_valid,
  input  logic [4:0]       wb_s_reg,
  input  logic             wb_v_valid,
  input  logic [4:0]       wb_v_reg,
  output logic             halted
);

  typedef enum logic [1:0] {StIdle, StHold, StSeq, StHalt} state_e;

  localparam logic [BeatW-1:0] LastBeat  = BeatW'(VBEATS - 1);
  localparam bit               MultiBeat = (VBEATS > 1);

  state_e                 r_state, w_state_d;
  logic                   r_valid, w_valid_d;
  ctrl_t                  r_ctrl, w_ctrl_d;
  logic [PC_W-1:0]        r_pc, w_pc_d;
  logic [BeatW-1:0]       r_beat, w_beat_d;
  logic                   r_last, w_last_d;
  logic [NUM_SREGS-1:0]   r_sb_s, w_sb_s_d;
  logic [NUM_VREGS-1:0]   r_sb_v, w_sb_v_d;

  ctrl_t w_dec;
  logic  w_flush, w_hs, w_accept, w_retire, w_hazard;
  logic  w_held_s, w_held_v;

  inst_decoder u_dec (
    .i_inst (in_inst),
    .o_ctrl (w_dec)
  );

  // Flush is ignored once halted.
  assign w_flush  = flush & (r_state != StHalt);
  assign w_hs     = r_valid & out_ready;
  assign w_retire = w_hs & r_last & ~w_flush;

  // The held micro-op's destination counts as busy until it retires into the scoreboard.
  assign w_held_s = r_valid & r_ctrl.r_write;
  assign w_held_v = r_valid & r_ctrl.v_write;

  assign w_hazard =
      (w_dec.r_read1 & (r_sb_s[w_dec.rs1] | (w_held_s & (r_ctrl.rd == w_dec.rs1)))) |
      (w_dec.r_read2 & (r_sb_s[w_dec.rs2] | (w_held_s & (r_ctrl.rd == w_dec.rs2)))) |
      (w_dec.r_write & (r_sb_s[w_dec.rd]  | (w_held_s & (r_ctrl.rd == w_dec.rd))))  |
      (w_dec.v_read1 & (r_sb_v[w_dec.rs1] | (w_held_v & (r_ctrl.rd == w_dec.rs1)))) |
      (w_dec.v_read2 & (r_sb_v[w_dec.rs2] | (w_held_v & (r_ctrl.rd == w_dec.rs2)))) |
      (w_dec.v_write & (r_sb_v[w_dec.rd]  | (w_held_v & (r_ctrl.rd == w_dec.rd))));

  // A held halt must not let a younger instruction slip in behind it.
  assign in_ready = (r_state != StHalt) &
                    (~r_valid | (out_ready & r_last & ~r_ctrl.halt)) &
                    ~w_hazard & ~flush;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_d = r_state;
    w_valid_d = r_valid;
    w_ctrl_d  = r_ctrl;
    w_pc_d    = r_pc;
    w_beat_d  = r_beat;
    w_last_d  = r_last;
    if (w_flush) begin
      w_state_d = StIdle;
      w_valid_d = 1'b0;
    end else begin
      if (w_hs) begin
        if (r_ctrl.halt) begin
          w_state_d = StHalt;
          w_valid_d = 1'b0;
        end else if (!r_last) begin
          w_beat_d = r_beat + 1'b1;
          w_last_d = ((r_beat + 1'b1) == LastBeat);
        end else begin
          w_state_d = StIdle;
          w_valid_d = 1'b0;
        end
      end
      if (w_accept) begin
        w_valid_d = 1'b1;
        w_ctrl_d  = w_dec;
        w_pc_d    = in_pc;
        w_beat_d  = '0;
        w_last_d  = ~(w_dec.vmem & MultiBeat);
        w_state_d = (w_dec.vmem & MultiBeat) ? StSeq : StHold;
      end
    end
  end

  // Clears first, then sets, so a same-cycle retire keeps the bit set.
  always_comb begin
    w_sb_s_d = r_sb_s;
    w_sb_v_d = r_sb_v;
    if (wb_s_valid) w_sb_s_d[wb_s_reg] = 1'b0;
    if (wb_v_valid) w_sb_v_d[wb_v_reg] = 1'b0;
    if (w_retire && r_ctrl.r_write) w_sb_s_d[r_ctrl.rd] = 1'b1;
    if (w_retire && r_ctrl.v_write) w_sb_v_d[r_ctrl.rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
      r_beat  <= '0;
      r_last  <= 1'b0;
      r_sb_s  <= '0;
      r_sb_v  <= '0;
    end else begin
      r_valid <= w_valid_d;
      r_ctrl  <= w_ctrl_d;
      r_pc    <= w_pc_d;
      r_beat  <= w_beat_d;
      r_last  <= w_last_d;
      r_sb_s  <= w_sb_s_d;
      r_sb_v  <= w_sb_v_d;
    end
  end

  assign out_valid = r_valid;
  assign out_ctrl  = r_ctrl;
  assign out_pc    = r_pc;
  assign out_beat  = r_beat;
  assign out_last  = r_last;
  assign halted    = (r_state == StHalt);

endmodule

// File: tb/tb_decode_sequencer.sv
module tb_decode_sequencer;
  import decode_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic        flush, out_valid, out_ready, out_last;
  ctrl_t       out_ctrl;
  logic [31:0] out_pc;
  logic [1:0]  out_beat;
  logic        wb_s_valid, wb_v_valid, halted;
  logic [4:0]  wb_s_reg, wb_v_reg;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  decode_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_pc     (out_pc),
    .out_beat   (out_beat),
    .out_last   (out_last),
    .wb_s_valid (wb_s_valid),
    .wb_s_reg   (wb_s_reg),
    .wb_v_valid (wb_v_valid),
    .wb_v_reg   (wb_v_reg),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    logic [31:0] o, d, s1, s2, im;
    o = op; d = rd; s1 = rs1; s2 = rs2; im = imm;
    return {o[6:0], d[4:0], s1[4:0], s2[4:0], im[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 0;
    wb_s_valid = 0; wb_s_reg = 0; wb_v_valid = 0; wb_v_reg = 0;
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_beat", out_beat, 0);
    chk("rst_last", out_last, 0);
    chk("rst_halted", halted, 0);
    rst = 1'b0;

    // addi r3 = r0 + 5, then addi r4 = r3 + 1 (RAW on r3)
    in_valid = 1; in_inst = enc(2, 3, 0, 0, 5); in_pc = 32'h100; out_ready = 1;
    #1 chk("a3_ready", in_ready, 1);
    tick();
    chk("a3_valid", out_valid, 1);
    chk("a3_pc", out_pc, 32'h100);
    chk("a3_rd", out_ctrl.rd, 3);
    chk("a3_rwrite", out_ctrl.r_write, 1);
    chk("a3_imm", out_ctrl.imm, 5);
    chk("a3_last", out_last, 1);
    in_inst = enc(2, 4, 3, 0, 1); in_pc = 32'h104;
    #1 chk("raw_held", in_ready, 0);
    tick();
    chk("a3_gone", out_valid, 0);
    chk("raw_sb", in_ready, 0);
    wb_s_valid = 1; wb_s_reg = 3;
    #1 chk("no_bypass", in_ready, 0);
    tick();
    wb_s_valid = 0;
    #1 chk("raw_cleared", in_ready, 1);
    tick();
    chk("a4_valid", out_valid, 1);
    chk("a4_pc", out_pc, 32'h104);
    chk("a4_rd", out_ctrl.rd, 4);
    in_valid = 0;
    tick();

    // vldr v2 (base r1, offset r5), then vadd v6 = v2 + v0
    in_valid = 1; in_inst = enc(12, 2, 1, 5, 0); in_pc = 32'h200;
    #1 chk("vldr_ready", in_ready, 1);
    tick();
    in_inst = enc(8, 6, 2, 0, 0); in_pc = 32'h204;
    #1;
    for (int b = 0; b < 4; b++) begin
      chk("vldr_beat", out_beat, b);
      chk("vldr_last", out_last, (b == 3));
      chk("vldr_pc", out_pc, 32'h200);
      chk("vldr_vwrite", out_ctrl.v_write, 1);
      chk("vadd_stall", in_ready, 0);
      tick();
    end
    chk("vldr_done", out_valid, 0);
    chk("vsb_set", in_ready, 0);
    wb_v_valid = 1; wb_v_reg = 2;
    tick();
    wb_v_valid = 0;
    #1 chk("vsb_cleared", in_ready, 1);
    tick();
    chk("vadd_pc", out_pc, 32'h204);
    chk("vadd_rd", out_ctrl.rd, 6);
    in_valid = 0;
    tick();

    // vldi v8, then independent addi r9 accepted as the last beat leaves
    in_valid = 1; in_inst = enc(10, 8, 0, 0, 4); in_pc = 32'h300;
    tick();
    in_inst = enc(2, 9, 0, 0, 0); in_pc = 32'h304;
    #1 chk("seq_block", in_ready, 0);
    tick(); tick(); tick();
    chk("vldi_b3", out_beat, 3);
    chk("overlap_ready", in_ready, 1);
    tick();
    chk("a9_pc", out_pc, 32'h304);
    chk("a9_beat", out_beat, 0);
    chk("a9_last", out_last, 1);
    out_ready = 0; in_valid = 0; in_inst = enc(2, 10, 0, 0, 0); in_pc = 32'h308;

    // Back-pressure: held micro-op stays stable
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", out_valid, 1);
      chk("stall_pc", out_pc, 32'h304);
      chk("stall_rd", out_ctrl.rd, 9);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    chk("release_one", out_valid, 0);

    // Flush during beat 1 of vstr
    in_valid = 1; in_inst = enc(13, 0, 0, 1, 0); in_pc = 32'h400;
    tick();
    in_inst = enc(2, 11, 0, 0, 0); in_pc = 32'h404;
    tick();
    chk("vstr_b1", out_beat, 1);
    flush = 1;
    #1 chk("flush_ready", in_ready, 0);
    tick();
    flush = 0;
    chk("flush_valid", out_valid, 0);
    #1 chk("post_flush_ready", in_ready, 1);
    tick();
    chk("a11_pc", out_pc, 32'h404);
    chk("a11_beat", out_beat, 0);
    chk("a11_last", out_last, 1);
    in_valid = 0;
    tick();

    // r7: writeback clear and retire set in the same cycle
    out_ready = 0; in_valid = 1; in_inst = enc(2, 7, 0, 0, 0); in_pc = 32'h500;
    tick();
    in_valid = 0; out_ready = 1; wb_s_valid = 1; wb_s_reg = 7;
    tick();
    wb_s_valid = 0; in_valid = 1; in_inst = enc(2, 12, 7, 0, 0); in_pc = 32'h504;
    #1 chk("set_wins", in_ready, 0);
    tick();
    chk("set_wins_2", in_ready, 0);
    wb_s_valid = 1; wb_s_reg = 7;
    tick();
    wb_s_valid = 0;
    #1 chk("r7_cleared", in_ready, 1);
    tick();
    chk("a12_pc", out_pc, 32'h504);
    in_valid = 0;
    tick();

    // Halt
    in_valid = 1; in_inst = enc(15, 0, 0, 0, 0); in_pc = 32'h600;
    tick();
    chk("halt_valid", out_valid, 1);
    chk("halt_ctrl", out_ctrl.halt, 1);
    in_inst = enc(2, 13, 0, 0, 0); in_pc = 32'h604;
    #1 chk("halt_held_ready", in_ready, 0);
    tick();
    chk("halted", halted, 1);
    chk("halted_valid", out_valid, 0);
    chk("halted_ready", in_ready, 0);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_in_halt", halted, 1);
    tick(); tick(); tick();
    chk("halt_sticky", in_ready, 0);

    // Reset out of halt, then undefined opcode and full throughput
    rst = 1;
    #1 chk("rst_unhalt", halted, 0);
    tick();
    rst = 0;
    in_valid = 1; in_inst = enc(127, 5, 6, 7, 3); in_pc = 32'h800;
    #1 chk("undef_ready", in_ready, 1);
    tick();
    chk("undef_ctrl", out_ctrl, 0);
    chk("undef_last", out_last, 1);
    chk("undef_pc", out_pc, 32'h800);
    in_inst = enc(2, 14, 0, 0, 0); in_pc = 32'h700;
    tick();
    chk("b2b_pc", out_pc, 32'h700);
    out_ready = 0; in_valid = 0;
    tick();
    chk("hold_pc", out_pc, 32'h700);
    rst = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_ctrl", out_ctrl, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_beat", out_beat, 0);
    tick();
    rst = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
# decode_sequencer

Registered, parametrised decode stage between instruction fetch and register read. Each accepted 32-bit instruction is decoded into a control bundle and held in a one-entry output register with valid/ready handshakes on both sides. Vector memory instructions (vldi, vsti, vldr, vstr) are expanded into `VBEATS` micro-ops. A scalar/vector register scoreboard stalls issue on read-after-write and write-after-write hazards, and the stage handles flush and halt.

## Interface
- `VBEATS`, 4: micro-ops per vector memory instruction; must be ≥1.
- `NUM_SREGS`, 32: scalar registers tracked by the scoreboard.
- `NUM_VREGS`, 32: vector registers tracked by the scoreboard.
- `PC_W`, 32: PC width.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `in_inst` input 32: instruction; opcode is bits [31:25].
- `in_pc` input PC_W: PC of the instruction.
- `flush` input 1: branch redirect; discards held and sequencing state.
- `out_valid` output 1: decoded micro-op is valid.
- `out_ready` input 1: register-read stage consumes the micro-op.
- `out_ctrl` output ctrl_t: decoded control bundle.
- `out_pc` output PC_W: PC of the micro-op.
- `out_beat` output $clog2(VBEATS) (min 1): micro-op index.
- `out_last` output 1: final micro-op of the instruction.
- `wb_s_valid` input 1: scalar writeback completes.
- `wb_s_reg` input 5: register for the scalar writeback.
- `wb_v_valid` input 1: vector writeback completes.
- `wb_v_reg` input 5: register for the vector writeback.
- `halted` output 1: a halt has been issued.

## Operation
- States: IDLE (output empty), HOLD (single micro-op held), SEQ (multi-beat expansion in progress), HALT.
- Reset values: state IDLE; `out_valid`=0, `out_ctrl`='0, `out_pc`=0, `out_beat`=0, `out_last`=0, `halted`=0; scoreboard all clear.
- Accept condition: `in_ready` = (state≠HALT) & (state≠SEQ or last beat leaving) & (!out_valid | out_ready) & !hazard & !flush.
- A hazard exists when any source register enabled by r_read1/2 or v_read1/2 is set in the scoreboard, or matches the destination of the held micro-op, or the instruction's own destination is busy (WAW). Unused register fields are ignored.
- Scoreboard bit for the destination (scalar and/or vector) is set at the output handshake of the micro-op with `out_last`=1. It is cleared by the matching `wb_*`.
- If a set and a clear hit the same register in the same cycle, the set wins.
- Hazard checks use registered scoreboard state; there is no writeback bypass.
- Vector memory op: beats 0..VBEATS-1 are emitted on consecutive handshakes with identical `out_ctrl`. `out_beat` increments and `out_last` is asserted only on the final beat. With VBEATS=1 such an op behaves as HOLD.
- All other opcodes produce one micro-op with `out_last`=1. Undefined opcodes decode to an all-zero bundle (nop).
- Halt: on the handshake of a halt micro-op, state goes to HALT and `halted`=1. `in_ready` stays 0 until `rst`. Writebacks continue clearing the scoreboard.
- Flush: clears `out_valid` and abandons SEQ; state goes to IDLE. Scoreboard bits already set are kept, because in-flight writes still complete. Flush has priority over a simultaneous handshake. `in_ready`=0 in the flush cycle. Flush in HALT has no effect.

## Timing
- Latency is 1 cycle: instruction accepted at edge N is presented on `out_*` after edge N.
- Full throughput: back-to-back single micro-ops with `out_ready`=1 give one per cycle.
- A vector memory op occupies VBEATS handshakes. A new instruction may be accepted in the cycle its last beat is consumed.
- A stalled instruction resolved by a writeback at edge N is accepted no earlier than edge N+1.
- `out_*` stay stable while `out_valid` & !`out_ready`.
- Reset asserted mid-operation returns all outputs to their reset values immediately; no handshake completes in that cycle.

## Structure
- Package `decode_pkg` holds:
  - the opcode enum;
  - `ctrl_t`, a packed struct of all control fields;
  - the imm_type, branch_jump and matmul_opcode constants;
  - the vector-ALU operation enum.
- Sub-module `inst_decoder` is purely combinational: inst → ctrl_t plus source/destination register fields and read/write enables. `decode_sequencer` holds the FSM, output register, beat counter and scoreboard.

## Test plan
- Addi r3 followed by Addi r4 reading r3, `out_ready`=1: first issues after 1 cycle. Second stalls until `wb_s_valid` with reg 3, then is accepted the cycle after.
- vldr with VBEATS=4: four micro-ops with `out_beat` 0,1,2,3, `out_last` only on beat 3, and vector scoreboard bit set after beat 3.
- `out_ready`=0 for 3 cycles with a valid held: `out_*` stable, `in_ready`=0. Releasing `out_ready` gives one handshake.
- Flush during beat 1 of vstr: `out_valid`=0 next cycle, state IDLE, next instruction accepted normally.
- Halt opcode issued: `halted`=1 and `in_ready`=0 permanently. Asserting `rst` mid-hold returns all outputs to 0.
- Same-cycle writeback clear and new writer set on r7: bit 7 remains set.
